rr_grant_ctrl: RTL and testbench

- Round-robin scheduler that shares one downstream resource among `NUM_REQ` requesters.
- Selects one requester at a time and holds the grant until the owner releases it, drops its request, or exceeds a hold limit.
- Presents the grant both as a binary index and as a one-hot vector, in the format our 4-to-16 decoder produces.
- Sits between the requester agents and the shared resource's select/enable logic.

---
 rtl/rr_grant_ctrl.sv | 173 +++++++++++++++++
 tb/tb_rr_grant_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_ctrl.sv
// rr_grant_ctrl: round-robin grant controller for one shared downstream resource.
// One requester owns the resource at a time; ownership ends on release, on the
// owner dropping its request, on enable going low, or when the hold limit is hit.
// The grant is presented both as a binary index and as a 4-to-16 style one-hot.
// The owner's "release" input is named release_req because "release" is a
// reserved SystemVerilog keyword.
module rr_grant_ctrl #(
    parameter int NUM_REQ  = 16,
    parameter int IDX_BITS = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                release_req,
    output logic                grant_valid,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic [NUM_REQ-1:0]  grant_onehot,
    output logic                timeout
);

    // The hold counter is sized for the largest legal MAX_HOLD (255).
    localparam int                   HOLD_BITS = 8;
    localparam logic [HOLD_BITS-1:0] HOLD_LAST = HOLD_BITS'(MAX_HOLD - 1);
    localparam logic [IDX_BITS-1:0]  LAST_RESET = IDX_BITS'(NUM_REQ - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IDX_BITS-1:0]  last_q;
    logic [IDX_BITS-1:0]  last_d;
    logic [HOLD_BITS-1:0] hold_cnt_q;
    logic [HOLD_BITS-1:0] hold_cnt_d;
    logic                 grant_valid_q;
    logic                 grant_valid_d;
    logic [IDX_BITS-1:0]  grant_idx_q;
    logic [IDX_BITS-1:0]  grant_idx_d;
    logic [NUM_REQ-1:0]   grant_onehot_q;
    logic [NUM_REQ-1:0]   grant_onehot_d;
    logic                 timeout_q;
    logic                 timeout_d;

    logic                 win_found;
    logic [IDX_BITS-1:0]  win_idx;
    logic [IDX_BITS-1:0]  cand_idx;
    logic                 grant_start;

    logic                 cause_release;
    logic                 cause_drop;
    logic                 cause_disable;
    logic                 cause_limit;
    logic                 grant_end;

    // Register all state and outputs; reset puts the pointer on the last
    // requester so requester 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_q         <= LAST_RESET;
            hold_cnt_q     <= '0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            hold_cnt_q     <= hold_cnt_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            timeout_q      <= timeout_d;
        end
    end

    // Rotating priority search: first set request after the last owner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand_idx = last_q + IDX_BITS'(i);
            if (!win_found && req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Decode why the current grant would end on this edge.
    always_comb begin
        grant_start   = enable && win_found;
        cause_release = release_req;
        cause_drop    = !req[grant_idx_q];
        cause_disable = !enable;
        cause_limit   = (hold_cnt_q == HOLD_LAST);
        grant_end     = cause_release || cause_drop || cause_disable || cause_limit;
    end

    // Next-state logic for the IDLE/GRANT controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_start) begin
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (grant_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values: load the winner, count hold cycles,
    // and on grant end move the pointer and flag a pure hold-limit timeout.
    always_comb begin
        last_d         = last_q;
        hold_cnt_d     = hold_cnt_q;
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        timeout_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                hold_cnt_d = '0;
                if (grant_start) begin
                    grant_valid_d  = 1'b1;
                    grant_idx_d    = win_idx;
                    grant_onehot_d = NUM_REQ'(1) << win_idx;
                end else begin
                    grant_valid_d  = 1'b0;
                    grant_idx_d    = '0;
                    grant_onehot_d = '0;
                end
            end
            ST_GRANT: begin
                if (grant_end) begin
                    last_d         = grant_idx_q;
                    hold_cnt_d     = '0;
                    grant_valid_d  = 1'b0;
                    grant_idx_d    = '0;
                    grant_onehot_d = '0;
                    timeout_d      = cause_limit && !(cause_release || cause_drop || cause_disable);
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                hold_cnt_d     = '0;
                grant_valid_d  = 1'b0;
                grant_idx_d    = '0;
                grant_onehot_d = '0;
            end
        endcase
    end

    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb_rr_grant_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the round-robin grant rules.
module tb_rr_grant_ctrl;

    localparam int NUM_REQ  = 16;
    localparam int IDX_BITS = 4;
    localparam int MAX_HOLD = 8;

    logic                clk;
    logic                rst_n;
    logic                enable;
    logic [NUM_REQ-1:0]  req;
    logic                release_req;
    logic                grant_valid;
    logic [IDX_BITS-1:0] grant_idx;
    logic [NUM_REQ-1:0]  grant_onehot;
    logic                timeout;

    int n_cmp;
    int n_err;

    // Behavioural model: owner (-1 = none), last owner, cycles visible so far.
    int          m_owner;
    int          m_last;
    int          m_visible;
    bit          m_timeout;
    logic        e_valid;
    logic [3:0]  e_idx;
    logic [15:0] e_onehot;
    logic        e_timeout;

    rr_grant_ctrl #(
        .NUM_REQ (NUM_REQ),
        .IDX_BITS(IDX_BITS),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .req         (req),
        .release_req (release_req),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_onehot(grant_onehot),
        .timeout     (timeout)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner   = -1;
        m_last    = NUM_REQ - 1;
        m_visible = 0;
        m_timeout = 0;
    endtask

    task automatic model_edge();
        bit r, d, e, t;
        if (m_owner < 0) begin
            m_timeout = 0;
            if (enable && req != 0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int c;
                    c = (m_last + k) % NUM_REQ;
                    if (req[c] && m_owner < 0) m_owner = c;
                end
                m_visible = 1;
            end
        end else begin
            r = release_req;
            d = !req[m_owner];
            e = !enable;
            t = (m_visible == MAX_HOLD);
            if (r || d || e || t) begin
                m_timeout = t && !(r || d || e);
                m_last    = m_owner;
                m_owner   = -1;
                m_visible = 0;
            end else begin
                m_timeout = 0;
                m_visible++;
            end
        end
        e_valid   = (m_owner >= 0);
        e_idx     = (m_owner >= 0) ? 4'(m_owner) : 4'd0;
        e_onehot  = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
        e_timeout = m_timeout;
    endtask

    // One clock: model follows the edge, outputs are then stable at +1.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        release_req = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        enable = 1'b1;
        req    = 16'h0000;
        do_reset();
        n_cmp++;
        if (grant_valid !== 1'b0 || grant_idx !== 4'd0 || grant_onehot !== 16'h0 || timeout !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_state: got v=%b idx=%0d oh=%h to=%b want all zero", grant_valid, grant_idx, grant_onehot, timeout);
        end
        req = 16'h0020;
        tick();
        n_cmp++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd5) begin
            n_err++;
            $display("[TB] FAIL reset_owner5: got v=%b idx=%0d want v=1 idx=5", grant_valid, grant_idx);
        end
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (grant_valid !== 1'b0 || grant_idx !== 4'd0 || grant_onehot !== 16'h0 || timeout !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_async: got v=%b idx=%0d oh=%h want zeros before edge", grant_valid, grant_idx, grant_onehot);
        end
        @(posedge clk);
        #1;
        req   = 16'hFFFF;
        rst_n = 1'b1;
        n_cmp++;
        if (grant_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_release_idle: got v=%b want 0", grant_valid);
        end
        tick();
        n_cmp++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd0 || grant_onehot !== 16'h0001) begin
            n_err++;
            $display("[TB] FAIL reset_first_grant: got v=%b idx=%0d oh=%h want v=1 idx=0 oh=0001", grant_valid, grant_idx, grant_onehot);
        end
    endtask

    task automatic test_round_robin();
        int exp_seq[5] = '{0, 5, 10, 15, 0};
        enable = 1'b1;
        req    = 16'h0000;
        do_reset();
        req = 16'h8421;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_cmp++;
            if (grant_valid !== 1'b1 || grant_idx !== 4'(exp_seq[k]) || grant_onehot !== (16'd1 << exp_seq[k])) begin
                n_err++;
                $display("[TB] FAIL rr_grant%0d: got v=%b idx=%0d oh=%h want idx=%0d", k, grant_valid, grant_idx, grant_onehot, exp_seq[k]);
            end
            release_req = 1'b1;
            tick();
            release_req = 1'b0;
            n_cmp++;
            if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL rr_gap%0d: got v=%b to=%b want 0 0", k, grant_valid, timeout);
            end
        end
    endtask

    task automatic test_wrap_fairness();
        int exp_seq[3] = '{15, 0, 14};
        enable = 1'b1;
        req    = 16'h0000;
        do_reset();
        req = 16'h4000;
        tick();
        release_req = 1'b1;
        tick();
        release_req = 1'b0;
        req = 16'hC001;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (grant_valid !== 1'b1 || grant_idx !== 4'(exp_seq[k])) begin
                n_err++;
                $display("[TB] FAIL wrap_grant%0d: got v=%b idx=%0d want idx=%0d", k, grant_valid, grant_idx, exp_seq[k]);
            end
            release_req = 1'b1;
            tick();
            release_req = 1'b0;
        end
    endtask

    task automatic test_timeout();
        int high_cycles;
        enable = 1'b1;
        req    = 16'h0000;
        do_reset();
        req = 16'h0010;
        high_cycles = 0;
        tick();
        for (int c = 0; c < 12 && grant_valid === 1'b1; c++) begin
            if (grant_idx === 4'd4 && timeout === 1'b0) high_cycles++;
            tick();
        end
        n_cmp++;
        if (high_cycles != MAX_HOLD) begin
            n_err++;
            $display("[TB] FAIL timeout_len: got %0d cycles want %0d", high_cycles, MAX_HOLD);
        end
        n_cmp++;
        if (grant_valid !== 1'b0 || timeout !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL timeout_pulse: got v=%b to=%b want v=0 to=1", grant_valid, timeout);
        end
        tick();
        n_cmp++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd4 || timeout !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL timeout_regrant: got v=%b idx=%0d to=%b want v=1 idx=4 to=0", grant_valid, grant_idx, timeout);
        end
    endtask

    task automatic test_early_end();
        enable = 1'b1;
        req    = 16'h0000;
        do_reset();
        req = 16'h0008;
        tick();
        tick();
        req = 16'h0000;
        tick();
        n_cmp++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL early_drop: got v=%b to=%b want 0 0", grant_valid, timeout);
        end
        req = 16'h0008;
        tick();
        for (int c = 0; c < MAX_HOLD - 1; c++) tick();
        n_cmp++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd3) begin
            n_err++;
            $display("[TB] FAIL early_last_cycle: got v=%b idx=%0d want v=1 idx=3", grant_valid, grant_idx);
        end
        release_req = 1'b1;
        tick();
        release_req = 1'b0;
        n_cmp++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL early_release_vs_limit: got v=%b to=%b want 0 0", grant_valid, timeout);
        end
    endtask

    task automatic test_enable();
        int granted;
        req    = 16'h0000;
        enable = 1'b0;
        do_reset();
        req     = 16'hFFFF;
        granted = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (grant_valid !== 1'b0) granted++;
        end
        n_cmp++;
        if (granted != 0) begin
            n_err++;
            $display("[TB] FAIL enable_block: got %0d granted cycles want 0", granted);
        end
        enable = 1'b1;
        tick();
        n_cmp++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd0) begin
            n_err++;
            $display("[TB] FAIL enable_first: got v=%b idx=%0d want v=1 idx=0", grant_valid, grant_idx);
        end
        enable = 1'b0;
        tick();
        n_cmp++;
        if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL enable_drop: got v=%b to=%b want 0 0", grant_valid, timeout);
        end
        enable = 1'b1;
        tick();
        n_cmp++;
        if (grant_valid !== 1'b1 || grant_idx !== 4'd1) begin
            n_err++;
            $display("[TB] FAIL enable_resume: got v=%b idx=%0d want v=1 idx=1", grant_valid, grant_idx);
        end
    endtask

    task automatic test_random();
        int bad;
        enable = 1'b1;
        req    = 16'h0000;
        do_reset();
        bad = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                req = 16'($urandom) & 16'($urandom);
            end
            release_req = ($urandom_range(0, 5) == 0);
            enable      = ($urandom_range(0, 15) != 0);
            tick();
            n_cmp++;
            if (grant_valid !== e_valid || grant_idx !== e_idx || grant_onehot !== e_onehot || timeout !== e_timeout) begin
                n_err++;
                if (bad < 10) begin
                    $display("[TB] FAIL random_c%0d: got v=%b idx=%0d oh=%h to=%b want v=%b idx=%0d oh=%h to=%b",
                             c, grant_valid, grant_idx, grant_onehot, timeout, e_valid, e_idx, e_onehot, e_timeout);
                end
                bad++;
            end
        end
        release_req = 1'b0;
    endtask

    // Run all scenarios in sequence, then print the summary.
    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        enable      = 1'b0;
        req         = '0;
        release_req = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_wrap_fairness();
        test_timeout();
        test_early_end();
        test_enable();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
